// File: rtl/traffic_pkg.sv
// Shared constants for the intersection phase sequencer: phase codes, lamp
// encodings and the duration counter width.
package traffic_pkg;

   localparam int DUR_W = 7;

   localparam logic [2:0] PH_NS_G  = 3'd0;
   localparam logic [2:0] PH_NS_Y  = 3'd1;
   localparam logic [2:0] PH_AR1   = 3'd2;
   localparam logic [2:0] PH_PED   = 3'd3;
   localparam logic [2:0] PH_EW_G  = 3'd4;
   localparam logic [2:0] PH_EW_Y  = 3'd5;
   localparam logic [2:0] PH_AR2   = 3'd6;
   localparam logic [2:0] PH_FLASH = 3'd7;

   localparam logic [2:0] LIGHT_RED = 3'b100;
   localparam logic [2:0] LIGHT_YEL = 3'b010;
   localparam logic [2:0] LIGHT_GRN = 3'b001;
   localparam logic [2:0] LIGHT_OFF = 3'b000;

   function automatic bit dur_ok(input int d);
      return (d >= 1) && (d <= 100);
   endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Tick/control inputs and lamp/display outputs of the phase sequencer.
// The slave modport is the controller; master is the tick generator/driver side.
interface traffic_phase_ctrl_if;
   import traffic_pkg::*;

   logic             tick;
   logic             en;
   logic             flash;
   logic             ped_req;
   logic             ped_ack;
   logic [2:0]       ns_light;
   logic [2:0]       ew_light;
   logic             walk;
   logic [2:0]       phase;
   logic [DUR_W-1:0] remain;

   modport master (
      output tick, en, flash, ped_req,
      input  ped_ack, ns_light, ew_light, walk, phase, remain
   );

   modport slave (
      input  tick, en, flash, ped_req,
      output ped_ack, ns_light, ew_light, walk, phase, remain
   );

endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter holding ticks remaining in the current phase.
// Load has priority over the decrement; the count saturates at zero.
module phase_timer
   import traffic_pkg::*;
#(
   parameter logic [DUR_W-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [DUR_W-1:0] load_val,
   input  logic             tick_en,
   output logic [DUR_W-1:0] count,
   output logic             last
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= RST_VAL;
      end else if (load) begin
         count <= load_val;
      end else if (tick_en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign last = (count == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer with pedestrian phase and flash mode.
// All lamp outputs come straight from flops so reset and phase changes never glitch.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   NS_G  0  | north-south green, east-west red
//   NS_Y  1  | north-south yellow
//   AR1   2  | all-red clearance before PED / EW
//   PED   3  | pedestrian walk, all vehicles red
//   EW_G  4  | east-west green, north-south red
//   EW_Y  5  | east-west yellow
//   AR2   6  | all-red clearance before NS (reset state)
//   FLASH 7  | fault/night mode, both yellows blink
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int pGREEN_NS = 30,
   parameter int pGREEN_EW = 25,
   parameter int pYELLOW   = 3,
   parameter int pALLRED   = 2,
   parameter int pPED      = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   traffic_phase_ctrl_if.slave  bus
);

   if (!dur_ok(pGREEN_NS) || !dur_ok(pGREEN_EW) || !dur_ok(pYELLOW) ||
       !dur_ok(pALLRED) || !dur_ok(pPED)) begin : g_bad_dur
      $error("traffic_phase_ctrl: every phase duration must be within 1..100");
   end

   localparam logic [DUR_W-1:0] LD_NS     = DUR_W'(pGREEN_NS - 1);
   localparam logic [DUR_W-1:0] LD_EW     = DUR_W'(pGREEN_EW - 1);
   localparam logic [DUR_W-1:0] LD_YELLOW = DUR_W'(pYELLOW - 1);
   localparam logic [DUR_W-1:0] LD_ALLRED = DUR_W'(pALLRED - 1);
   localparam logic [DUR_W-1:0] LD_PED    = DUR_W'(pPED - 1);

   logic [2:0]       phase_q, phase_d;
   logic             blink_q, blink_d;
   logic             pend_q, pend_d;
   logic             ack_q, ack_d;
   logic [2:0]       ns_q, ns_d;
   logic [2:0]       ew_q, ew_d;
   logic             walk_q, walk_d;

   logic             tmr_load;
   logic [DUR_W-1:0] tmr_load_val;
   logic             tmr_dec;
   logic             tmr_last;
   logic [DUR_W-1:0] tmr_count;

   phase_timer #(
      .RST_VAL (LD_ALLRED)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .tick_en  (tmr_dec),
      .count    (tmr_count),
      .last     (tmr_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PH_AR2;
         blink_q <= 1'b0;
         pend_q  <= 1'b0;
         ack_q   <= 1'b0;
         ns_q    <= LIGHT_RED;
         ew_q    <= LIGHT_RED;
         walk_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         blink_q <= blink_d;
         pend_q  <= pend_d;
         ack_q   <= ack_d;
         ns_q    <= ns_d;
         ew_q    <= ew_d;
         walk_q  <= walk_d;
      end
   end

   // flash has priority over everything, including a coincident tick and en=0
   always_comb begin
      phase_d      = phase_q;
      blink_d      = blink_q;
      ack_d        = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_dec      = 1'b0;
      if (bus.flash) begin
         if (phase_q != PH_FLASH) begin
            phase_d  = PH_FLASH;
            blink_d  = 1'b0;
            tmr_load = 1'b1;
         end else if (bus.tick) begin
            blink_d = ~blink_q;
         end
      end else if (phase_q == PH_FLASH) begin
         phase_d      = PH_AR2;
         tmr_load     = 1'b1;
         tmr_load_val = LD_ALLRED;
      end else if (bus.en && bus.tick) begin
         if (!tmr_last) begin
            tmr_dec = 1'b1;
         end else begin
            tmr_load = 1'b1;
            case (phase_q)
               PH_NS_G: begin
                  phase_d      = PH_NS_Y;
                  tmr_load_val = LD_YELLOW;
               end
               PH_NS_Y: begin
                  phase_d      = PH_AR1;
                  tmr_load_val = LD_ALLRED;
               end
               PH_AR1: begin
                  if (pend_q) begin
                     phase_d      = PH_PED;
                     tmr_load_val = LD_PED;
                     ack_d        = 1'b1;
                  end else begin
                     phase_d      = PH_EW_G;
                     tmr_load_val = LD_EW;
                  end
               end
               PH_PED: begin
                  phase_d      = PH_EW_G;
                  tmr_load_val = LD_EW;
               end
               PH_EW_G: begin
                  phase_d      = PH_EW_Y;
                  tmr_load_val = LD_YELLOW;
               end
               PH_EW_Y: begin
                  phase_d      = PH_AR2;
                  tmr_load_val = LD_ALLRED;
               end
               default: begin
                  phase_d      = PH_NS_G;
                  tmr_load_val = LD_NS;
               end
            endcase
         end
      end
      // a request arriving in the serving cycle is absorbed by that service
      pend_d = ack_d ? 1'b0 : (pend_q | bus.ped_req);
   end

   always_comb begin
      ns_d   = LIGHT_RED;
      ew_d   = LIGHT_RED;
      walk_d = 1'b0;
      case (phase_d)
         PH_NS_G:  ns_d = LIGHT_GRN;
         PH_NS_Y:  ns_d = LIGHT_YEL;
         PH_EW_G:  ew_d = LIGHT_GRN;
         PH_EW_Y:  ew_d = LIGHT_YEL;
         PH_PED:   walk_d = 1'b1;
         PH_FLASH: begin
            ns_d = blink_d ? LIGHT_YEL : LIGHT_OFF;
            ew_d = blink_d ? LIGHT_YEL : LIGHT_OFF;
         end
         default: ;
      endcase
   end

   assign bus.phase    = phase_q;
   assign bus.remain   = tmr_count;
   assign bus.ped_ack  = ack_q;
   assign bus.ns_light = ns_q;
   assign bus.ew_light = ew_q;
   assign bus.walk     = walk_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with short durations and a tick every 4 clk.
module tb_traffic_phase_ctrl;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   logic ack_seen;
   logic ack_after;

   traffic_phase_ctrl_if bus ();

   traffic_phase_ctrl #(
      .pGREEN_NS (4),
      .pGREEN_EW (3),
      .pYELLOW   (2),
      .pALLRED   (1),
      .pPED      (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // one tick period of 4 clk; records ped_ack right after the tick edge and one clk later
   task automatic tick_once(input logic with_ped);
      @(negedge clk);
      bus.tick    = 1'b1;
      bus.ped_req = with_ped;
      @(negedge clk);
      bus.tick    = 1'b0;
      bus.ped_req = 1'b0;
      ack_seen    = bus.ped_ack;
      @(negedge clk);
      ack_after   = bus.ped_ack;
      @(negedge clk);
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) tick_once(1'b0);
   endtask

   task automatic pulse_ped();
      @(negedge clk);
      bus.ped_req = 1'b1;
      @(negedge clk);
      bus.ped_req = 1'b0;
   endtask

   task automatic chk_state(input string tag, input logic [2:0] ph, input logic [6:0] rm);
      chk({tag, ".phase"}, 8'(bus.phase), 8'(ph));
      chk({tag, ".remain"}, 8'(bus.remain), 8'(rm));
   endtask

   task automatic chk_lights(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                             input logic wk);
      chk({tag, ".ns"}, 8'(bus.ns_light), 8'(ns));
      chk({tag, ".ew"}, 8'(bus.ew_light), 8'(ew));
      chk({tag, ".walk"}, 8'(bus.walk), 8'(wk));
   endtask

   logic [2:0] s1_ph [14] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2,
                              3'd4, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd0};
   logic [6:0] s1_rm [14] = '{7'd3, 7'd2, 7'd1, 7'd0, 7'd1, 7'd0, 7'd0,
                              7'd2, 7'd1, 7'd0, 7'd1, 7'd0, 7'd0, 7'd3};
   logic [2:0] s1_ns [14] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100,
                              3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
   logic [2:0] s1_ew [14] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                              3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};

   initial begin
      rst_n       = 1'b0;
      bus.tick    = 1'b0;
      bus.en      = 1'b1;
      bus.flash   = 1'b0;
      bus.ped_req = 1'b0;
      ack_seen    = 1'b0;
      ack_after   = 1'b0;
      repeat (3) @(negedge clk);

      chk_state("rst", 3'd6, 7'd0);
      chk_lights("rst", 3'b100, 3'b100, 1'b0);
      chk("rst.ack", 8'(bus.ped_ack), 8'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk_state("idle", 3'd6, 7'd0);

      // normal loop without pedestrian
      for (int i = 0; i < 14; i++) begin
         tick_once(1'b0);
         chk_state($sformatf("loop%0d", i), s1_ph[i], s1_rm[i]);
         chk_lights($sformatf("loop%0d", i), s1_ns[i], s1_ew[i], 1'b0);
         chk($sformatf("loop%0d.ack", i), 8'(ack_seen), 8'd0);
      end

      // pedestrian request during NS_G
      pulse_ped();
      run_ticks(6);
      chk_state("ped.ar1", 3'd2, 7'd0);
      tick_once(1'b0);
      chk_state("ped.entry", 3'd3, 7'd1);
      chk("ped.ack", 8'(ack_seen), 8'd1);
      chk("ped.ack_one", 8'(ack_after), 8'd0);
      chk_lights("ped", 3'b100, 3'b100, 1'b1);
      tick_once(1'b0);
      chk_state("ped.last", 3'd3, 7'd0);
      tick_once(1'b0);
      chk_state("ped.ewg", 3'd4, 7'd2);
      chk_lights("ped.ewg", 3'b100, 3'b001, 1'b0);

      // request coincident with the AR1->PED transition
      run_ticks(6);
      chk_state("co.nsg", 3'd0, 7'd3);
      pulse_ped();
      run_ticks(6);
      chk_state("co.ar1", 3'd2, 7'd0);
      tick_once(1'b1);
      chk_state("co.ped", 3'd3, 7'd1);
      chk("co.ack", 8'(ack_seen), 8'd1);
      run_ticks(2);
      chk_state("co.ewg", 3'd4, 7'd2);
      run_ticks(13);
      chk_state("co.skip", 3'd4, 7'd2);
      chk("co.skip_ack", 8'(ack_seen), 8'd0);

      // en held low for 10 ticks mid-EW_G
      tick_once(1'b0);
      chk_state("en.pre", 3'd4, 7'd1);
      bus.en = 1'b0;
      run_ticks(10);
      chk_state("en.frozen", 3'd4, 7'd1);
      chk_lights("en.frozen", 3'b100, 3'b001, 1'b0);
      bus.en = 1'b1;
      @(negedge clk);
      chk_state("en.resume", 3'd4, 7'd1);
      tick_once(1'b0);
      chk_state("en.t1", 3'd4, 7'd0);
      tick_once(1'b0);
      chk_state("en.t2", 3'd5, 7'd1);
      chk_lights("en.t2", 3'b100, 3'b010, 1'b0);

      // flash mode from NS_G
      run_ticks(3);
      chk_state("fl.nsg", 3'd0, 7'd3);
      @(negedge clk);
      bus.flash = 1'b1;
      @(negedge clk);
      chk_state("fl.entry", 3'd7, 7'd0);
      chk_lights("fl.entry", 3'b000, 3'b000, 1'b0);
      tick_once(1'b0);
      chk_lights("fl.b1", 3'b010, 3'b010, 1'b0);
      chk_state("fl.b1", 3'd7, 7'd0);
      tick_once(1'b0);
      chk_lights("fl.b2", 3'b000, 3'b000, 1'b0);
      tick_once(1'b0);
      chk_lights("fl.b3", 3'b010, 3'b010, 1'b0);
      @(negedge clk);
      bus.flash = 1'b0;
      @(negedge clk);
      chk_state("fl.exit", 3'd6, 7'd0);
      chk_lights("fl.exit", 3'b100, 3'b100, 1'b0);
      tick_once(1'b0);
      chk_state("fl.nsg2", 3'd0, 7'd3);

      // asynchronous reset in the middle of PED
      pulse_ped();
      run_ticks(7);
      chk_state("rp.ped", 3'd3, 7'd1);
      chk("rp.walk", 8'(bus.walk), 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_state("rp.async", 3'd6, 7'd0);
      chk_lights("rp.async", 3'b100, 3'b100, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick_once(1'b0);
      chk_state("rp.nsg", 3'd0, 7'd3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
